// File: rtl/prbs_gen_check_if.sv
// prbs_gen_check_if: control, generator and checker signals of prbs_gen_check
//   master: testbench / link-control side, slave: prbs_gen_check side
interface prbs_gen_check_if #(
    parameter int WORDWIDTH = 16,
    parameter int CNTWIDTH  = 16
);
    logic                 dis;
    logic                 load;
    logic [1:0]           mode;
    logic [30:0]          seed;
    logic [WORDWIDTH-1:0] prbs_out;
    logic                 prbs_valid;
    logic [WORDWIDTH-1:0] chk_data;
    logic                 chk_valid;
    logic                 err_clr;
    logic                 locked;
    logic                 err_flag;
    logic [CNTWIDTH-1:0]  err_count;

    modport master (
        output dis, load, mode, seed, chk_data, chk_valid, err_clr,
        input  prbs_out, prbs_valid, locked, err_flag, err_count
    );

    modport slave (
        input  dis, load, mode, seed, chk_data, chk_valid, err_clr,
        output prbs_out, prbs_valid, locked, err_flag, err_count
    );
endinterface

// File: rtl/prbs_gen_check.sv
// prbs_gen_check: multi-polynomial PRBS word generator and self-synchronising checker
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   bus.dis/load    : generator hold / reseed and checker restart
//   bus.mode/seed   : polynomial select (PRBS7/15/23/31) and seed, latched on reset/load
//   bus.prbs_out/_valid : generated word, bit 0 earliest
//   bus.chk_data/_valid : received word, bit 0 earliest
//   bus.err_clr     : clear error counter
//   bus.locked/err_flag/err_count : checker status
module prbs_gen_check #(
    parameter int WORDWIDTH  = 16,
    parameter int CNTWIDTH   = 16,
    parameter int LOCK_WORDS = 4,
    parameter int LOSS_WORDS = 4
) (
    input logic              clk,
    input logic              reset,
    prbs_gen_check_if.slave  bus
);
    localparam int HW = $clog2((LOCK_WORDS > LOSS_WORDS ? LOCK_WORDS : LOSS_WORDS) + 1);
    localparam int PW = $clog2(WORDWIDTH + 1);
    localparam int SW = (CNTWIDTH > PW ? CNTWIDTH : PW) + 1;

    typedef enum logic {HUNT, LOCKED} state_t;

    function automatic logic [4:0] poly_n(input logic [1:0] m);
        return m == 2'd0 ? 5'd7 : m == 2'd1 ? 5'd15 : m == 2'd2 ? 5'd23 : 5'd31;
    endfunction

    function automatic logic [4:0] poly_m(input logic [1:0] m);
        return m == 2'd0 ? 5'd6 : m == 2'd1 ? 5'd14 : m == 2'd2 ? 5'd18 : 5'd28;
    endfunction

    logic [1:0]           mode_q;
    logic [4:0]           gn, gm;
    logic [30:0]          seed_mask, seed_ld;
    logic [30:0]          r_q, r_d;
    logic [WORDWIDTH-1:0] prbs_out_q, prbs_out_d;
    logic                 prbs_valid_q;

    state_t               state_q;
    logic [HW-1:0]        hcnt_q;
    logic [30:0]          h_q, h_d;
    logic [6:0]           fill_q, fill_d;
    logic [WORDWIDTH-1:0] e;
    logic [PW-1:0]        pop;
    logic                 compared;
    logic [SW-1:0]        sum;
    logic [CNTWIDTH-1:0]  cnt_sat;
    logic                 count_en;
    logic                 locked_q, err_flag_q;
    logic [CNTWIDTH-1:0]  err_count_q;

    assign gn = poly_n(mode_q);
    assign gm = poly_m(mode_q);

    // Seed is taken with the incoming mode, since mode_q is latched on the same edge.
    always_comb begin
        seed_mask = 31'((32'd1 << poly_n(bus.mode)) - 32'd1);
        seed_ld   = (bus.seed & seed_mask) == '0 ? seed_mask : bus.seed & seed_mask;
    end

    // WORDWIDTH serial steps unrolled; bits at and above N stay zero through the shift.
    always_comb begin
        r_d        = r_q;
        prbs_out_d = '0;
        for (int i = 0; i < WORDWIDTH; i++) begin
            prbs_out_d[i] = r_d[0];
            r_d = {1'b0, r_d[30:1]} | ({30'd0, r_d[0] ^ r_d[gn - gm]} << (gn - 5'd1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q       <= bus.mode;
            r_q          <= seed_ld;
            prbs_out_q   <= '0;
            prbs_valid_q <= 1'b0;
        end else if (bus.load) begin
            mode_q       <= bus.mode;
            r_q          <= seed_ld;
            prbs_valid_q <= 1'b0;
        end else if (!bus.dis) begin
            r_q          <= r_d;
            prbs_out_q   <= prbs_out_d;
            prbs_valid_q <= 1'b1;
        end else begin
            prbs_valid_q <= 1'b0;
        end
    end

    // History h[i] is the bit received i+1 bits ago, so s[k-M] = h[M-1], s[k-N] = h[N-1].
    always_comb begin
        h_d = h_q;
        e   = '0;
        pop = '0;
        for (int i = 0; i < WORDWIDTH; i++) begin
            e[i] = bus.chk_data[i] ^ h_d[gm - 5'd1] ^ h_d[gn - 5'd1];
            h_d  = {h_d[29:0], bus.chk_data[i]};
            pop  = pop + PW'(e[i]);
        end
    end

    // A word is compared only when the full history existed before its first bit.
    assign compared = fill_q >= 7'(gn);
    assign fill_d   = compared ? fill_q : fill_q + 7'(WORDWIDTH);
    assign sum      = SW'(err_count_q) + SW'(pop);
    assign cnt_sat  = sum > SW'({CNTWIDTH{1'b1}}) ? '1 : sum[CNTWIDTH-1:0];
    assign count_en = !bus.load && bus.chk_valid && compared && state_q == LOCKED;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= HUNT;
            hcnt_q      <= '0;
            h_q         <= '0;
            fill_q      <= '0;
            locked_q    <= 1'b0;
            err_flag_q  <= 1'b0;
            err_count_q <= '0;
        end else begin
            err_flag_q  <= 1'b0;
            err_count_q <= bus.err_clr ? '0 : count_en ? cnt_sat : err_count_q;
            if (bus.load) begin
                state_q  <= HUNT;
                hcnt_q   <= '0;
                h_q      <= '0;
                fill_q   <= '0;
                locked_q <= 1'b0;
            end else if (bus.chk_valid) begin
                h_q    <= h_d;
                fill_q <= fill_d;
                if (compared && state_q == HUNT) begin
                    if (pop != '0) begin
                        hcnt_q <= '0;
                    end else if (hcnt_q == HW'(LOCK_WORDS - 1)) begin
                        state_q  <= LOCKED;
                        locked_q <= 1'b1;
                        hcnt_q   <= '0;
                    end else begin
                        hcnt_q <= hcnt_q + HW'(1);
                    end
                end else if (compared) begin
                    err_flag_q <= pop != '0;
                    if (pop == '0) begin
                        hcnt_q <= '0;
                    end else if (hcnt_q == HW'(LOSS_WORDS - 1)) begin
                        state_q  <= HUNT;
                        locked_q <= 1'b0;
                        hcnt_q   <= '0;
                    end else begin
                        hcnt_q <= hcnt_q + HW'(1);
                    end
                end
            end
        end
    end

    assign bus.prbs_out   = prbs_out_q;
    assign bus.prbs_valid = prbs_valid_q;
    assign bus.locked     = locked_q;
    assign bus.err_flag   = err_flag_q;
    assign bus.err_count  = err_count_q;
endmodule

// File: tb/tb_prbs_gen_check.sv
// tb_prbs_gen_check: scoreboard bench for prbs_gen_check in 8-bit loopback
module tb_prbs_gen_check;
    logic        clk = 1'b0;
    logic        reset, dis, load, err_clr, lb;
    logic [1:0]  mode;
    logic [30:0] seed;
    logic [7:0]  flip, alt;

    always #12 clk = ~clk;

    prbs_gen_check_if #(.WORDWIDTH(8), .CNTWIDTH(16)) b0 ();
    prbs_gen_check_if #(.WORDWIDTH(8), .CNTWIDTH(4))  b1 ();

    prbs_gen_check #(.WORDWIDTH(8), .CNTWIDTH(16), .LOCK_WORDS(4), .LOSS_WORDS(4))
        dut0 (.clk(clk), .reset(reset), .bus(b0));
    prbs_gen_check #(.WORDWIDTH(8), .CNTWIDTH(4), .LOCK_WORDS(4), .LOSS_WORDS(4))
        dut1 (.clk(clk), .reset(reset), .bus(b1));

    assign b0.dis = dis;  assign b0.load = load;  assign b0.mode = mode;
    assign b0.seed = seed;  assign b0.err_clr = err_clr;
    assign b0.chk_data  = lb ? b0.prbs_out ^ flip : alt;
    assign b0.chk_valid = lb ? b0.prbs_valid : 1'b1;
    assign b1.dis = dis;  assign b1.load = load;  assign b1.mode = mode;
    assign b1.seed = seed;  assign b1.err_clr = err_clr;
    assign b1.chk_data  = lb ? b1.prbs_out ^ flip : alt;
    assign b1.chk_valid = lb ? b1.prbs_valid : 1'b1;

    typedef struct {logic l; logic f; int c;} cexp_t;

    int         errs = 0, checks = 0;
    int         mn, mm;
    bit         sq[$];
    logic [7:0] gq[$];
    cexp_t      cq[$];
    logic [7:0] last_out = '0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    function automatic void reseed(input logic [1:0] md, input logic [30:0] sd);
        logic [30:0] mask, v;
        mn   = md == 0 ? 7 : md == 1 ? 15 : md == 2 ? 23 : 31;
        mm   = md == 0 ? 6 : md == 1 ? 14 : md == 2 ? 18 : 28;
        mask = (31'd1 << mn) - 31'd1;
        v    = sd & mask;
        if (v == '0) v = mask;
        sq.delete();
        for (int i = 0; i < mn; i++) sq.push_back(v[i]);
    endfunction

    // s[j] = s[j-N] ^ s[j-M], with sq holding s[j-N..j-1]
    function automatic logic [7:0] next_word();
        logic [7:0] w;
        bit         b, o;
        for (int i = 0; i < 8; i++) begin
            b    = sq[0] ^ sq[mn - mm];
            o    = sq.pop_front();
            w[i] = o;
            sq.push_back(b);
        end
        return w;
    endfunction

    task automatic step(input bit ce = 0, input bit el = 0, input bit ef = 0, input int ec = 0);
        bit    exp_v, was_rst, was_dis;
        cexp_t c;
        was_rst = reset;
        was_dis = dis && !load && !reset;
        exp_v   = 1'b0;
        if (reset || load) reseed(mode, seed);
        else if (!dis) begin
            gq.push_back(next_word());
            exp_v = 1'b1;
        end
        if (ce) cq.push_back('{el, ef, ec});
        @(posedge clk);
        #1;
        chk("prbs_valid", 32'(b0.prbs_valid), 32'(exp_v));
        if (exp_v) begin
            last_out = gq.pop_front();
            chk("prbs_out", 32'(b0.prbs_out), 32'(last_out));
        end else if (was_rst) begin
            last_out = '0;
            chk("prbs_out_reset", 32'(b0.prbs_out), 32'd0);
        end else if (was_dis) begin
            chk("prbs_out_hold", 32'(b0.prbs_out), 32'(last_out));
        end
        if (cq.size() != 0) begin
            c = cq.pop_front();
            chk("locked", 32'(b0.locked), 32'(c.l));
            chk("err_flag", 32'(b0.err_flag), 32'(c.f));
            if (c.c >= 0) chk("err_count", 32'(b0.err_count), c.c);
        end
    endtask

    initial begin
        reset = 1; dis = 0; load = 0; err_clr = 0; lb = 1;
        mode = 0; seed = 31'h7F; flip = 0; alt = 0;
        step(1, 0, 0, 0);
        chk("cnt4_reset", 32'(b1.err_count), 0);
        reset = 0;
        step();
        chk("p7_word0", 32'(b0.prbs_out), 32'h7F);
        step();
        chk("p7_word1", 32'(b0.prbs_out), 32'h20);
        repeat (3) step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        repeat (4096) step();
        step(1, 1, 0, 0);

        flip = 8'h01;
        step(1, 1, 1, 3);
        chk("cnt4_inject", 32'(b1.err_count), 3);
        flip = 8'h00;
        step(1, 1, 0, 3);
        err_clr = 1;
        step(1, 1, 0, 0);
        err_clr = 0;

        lb = 0; alt = 8'h55;
        repeat (3) step(1, 1, 1, -1);
        step(1, 0, 1, -1);
        chk("cnt4_saturate", 32'(b1.err_count), 15);
        chk("cnt16_above15", 32'(b0.err_count > 16'd15), 1);
        lb = 1;
        repeat (3) step(1, 0, 0, -1);
        repeat (2) step();
        chk("relock", 32'(b0.locked), 1);

        dis = 1; mode = 2;
        repeat (3) step(1, 1, 0, -1);
        dis = 0;
        repeat (20) step();
        step(1, 1, 0, -1);

        load = 1; mode = 3; seed = 31'h1;
        step(1, 0, 0, -1);
        chk("load_keeps_cnt", 32'(b1.err_count), 15);
        load = 0;
        step();
        chk("p31_word0", 32'(b0.prbs_out), 32'h01);
        step();
        chk("p31_word1", 32'(b0.prbs_out), 32'h00);
        repeat (6) step(1, 0, 0, -1);
        step(1, 1, 0, -1);
        repeat (100) step();

        reset = 1; mode = 1; seed = 31'h0;
        step(1, 0, 0, 0);
        reset = 0;
        step();
        chk("zs_word0", 32'(b0.prbs_out), 32'hFF);
        step();
        chk("zs_word1", 32'(b0.prbs_out), 32'h7F);
        repeat (200) step();
        step(1, 1, 0, 0);
        chk("cnt4_zs", 32'(b1.err_count), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/prbs_gen_check.md
# prbs_gen_check

Parametrised multi-polynomial PRBS word generator with a self-synchronising PRBS checker. It succeeds the fixed PRBS15 source in the ETROC2 readout and serves as the test-pattern source and link-integrity checker on the serializer data path. Generator and checker share one clock and one polynomial selection but run independent data streams.

## Interface
- `WORDWIDTH`, default 16: bits produced or checked per cycle. Legal range 1..32.
- `CNTWIDTH`, default 16: width of the error counter.
- `LOCK_WORDS`, default 4: consecutive clean words needed to reach LOCKED.
- `LOSS_WORDS`, default 4: consecutive errored words that force a return to HUNT.
- `clk` in 1: 40 MHz clock. Everything is rising-edge.
- `reset` in 1: synchronous, active-high.
- `dis` in 1: generator hold.
- `load` in 1: reload the seed and restart the checker.
- `mode` in 2: polynomial select. 0 = PRBS7 x^7+x^6+1, 1 = PRBS15 x^15+x^14+1, 2 = PRBS23 x^23+x^18+1, 3 = PRBS31 x^31+x^28+1.
- `seed` in 31: generator seed. Only the low N bits are used.
- `prbs_out` out WORDWIDTH: generated word. Bit 0 is the earliest in time.
- `prbs_valid` out 1: `prbs_out` holds a new word this cycle.
- `chk_data` in WORDWIDTH: received word. Bit 0 is the earliest in time.
- `chk_valid` in 1: `chk_data` is valid this cycle.
- `err_clr` in 1: clear `err_count`.
- `locked` out 1: checker is in the LOCKED state.
- `err_flag` out 1: the last checked word had at least one error while LOCKED.
- `err_count` out CNTWIDTH: saturating count of error bits.

## Operation
- **Polynomial parameters.** N/M = 7/6, 15/14, 23/18, 31/28. `mode` is latched into `mode_q` on `reset` or `load`. Between those events, changes on `mode` are ignored.
- **Generator state.** Register `r[30:0]` holds the LFSR; bits at and above N are held at 0.
  - One serial step: output `r[0]`, then `r[N-1:0] <= {r[0]^r[N-M], r[N-1:1]}`.
  - Equivalent sequence relation: `s[j] = s[j-N] ^ s[j-M]`.
- **Seed handling.** On `reset` or `load`, `r <= seed[N-1:0]`. If that value is all zero, load all-ones in the low N bits instead, to avoid lock-up.
- **Word generation.** Each cycle with `dis`=0 and no `reset`/`load`:
  - `prbs_out <=` the next WORDWIDTH serial bits.
  - `r` advances WORDWIDTH steps.
  - `prbs_valid <= 1`.
- **Hold.** `dis`=1 holds `r` and `prbs_out`, and drives `prbs_valid <= 0`.
- **Checker history.** The checker keeps the last N received bits.
  - Error bit for each received bit: `e[k] = s[k] ^ s[k-M] ^ s[k-N]`.
  - A bit is compared only once N earlier bits exist since the last reset/load.
  - Words with incomplete history ("fill words") are not compared. That is ceil(N/WORDWIDTH) words.
- **Checker FSM.**
  - HUNT: count consecutive compared words with zero error bits. When the count reaches LOCK_WORDS, go to LOCKED. Any errored word resets the count.
  - LOCKED: each compared word adds popcount(e) to `err_count`. `err_flag` is driven to (popcount > 0).
  - LOSS_WORDS consecutive errored words in LOCKED return the FSM to HUNT. The count is cleared and history is kept.
  - Errors found in HUNT are never counted.
- **Error counter.** `err_count` saturates at 2^CNTWIDTH-1.
- **Clear collision.** `err_clr` wins over an increment in the same cycle; that word's errors are dropped.
- **Checker idle.** `chk_valid`=0 leaves all checker state unchanged and drives `err_flag <= 0`.
- **Single bit flip.** One flipped received bit produces 3 error bits, at k, k+M and k+N.

## Timing
- **Reset values.** After `reset`:
  - `prbs_out`=0, `prbs_valid`=0, `locked`=0, `err_flag`=0, `err_count`=0.
  - FSM in HUNT, history empty, `r` = seed (zero-substituted).
- **Generator latency.** The first `prbs_out` word appears with `prbs_valid`=1 on the first edge after reset deasserts with `dis`=0. It contains the sequence starting at s0, the seed's bit 0.
- **Load.**
  - Acts like reset for `r`, `mode_q`, checker history and FSM: FSM returns to HUNT, `locked` <= 0.
  - `prbs_valid` <= 0.
  - `err_count` is NOT cleared.
- **Priority.** `reset` > `load` > `dis`.
- **Checker latency.** A word sampled with `chk_valid` at edge t updates `locked`, `err_flag` and `err_count` at edge t. The outputs are registered and visible the cycle after.
- **Lock time.** `locked` rises ceil(N/WORDWIDTH)+LOCK_WORDS valid words after reset/load, given a clean stream.
- **Back-to-back operation.** The generator produces a new word every enabled cycle. The checker accepts a new word every cycle.

## Test plan
- **Basic PRBS7 output.** WORDWIDTH=8, mode=0, seed=0x7F, reset, then `dis`=0. Required: `prbs_out` = 0x7F, then 0x20, with `prbs_valid`=1 each cycle.
- **Zero seed.** seed=0, mode=1. Required: behaviour identical to seed=0x7FFF. The stream is never stuck at 0.
- **Loopback lock.** `prbs_out` and `prbs_valid` looped to `chk_data` and `chk_valid`, mode=0, WORDWIDTH=8. Required: `locked`=1 after the 5th valid word; `err_count` stays 0 over 2^12 words.
- **Single-bit injection.** Same loopback, locked. Flip bit 0 of one word. Required: `err_count`=3, `err_flag` pulses, `locked` stays 1. Then assert `err_clr` together with a clean word: `err_count`=0.
- **Loss of lock.** Same loopback, locked. Drive random `chk_data` for 4 words. Required: `locked`=0 after the 4th word. Returning to loopback relocks after 4 clean words, without a new fill.
- **dis / load / mode.** Assert `dis` for 3 cycles: `prbs_out` held, `prbs_valid`=0, and the sequence resumes without skipping. Then `load` with mode=3 and seed=1: the next word starts a PRBS31 sequence from s0=1, and `locked`=0. Also run `err_count` saturation with CNTWIDTH=4: the count stops at 15.
